// File: rtl/async_level_sync.sv
// async_level_sync: brings an asynchronous level-type bus into the DST_CLK domain,
//   with an optional stability filter so a multi-bit word never appears half-updated.
// Latency: STAGES edges in bypass mode, STAGES+2+FILTER_CYCLES edges when filtered.
// Backpressure: none. The source must hold each value long enough to be sampled.
// Ports:
//   DST_CLK        destination clock, rising edge
//   DST_RESET_IN   async active-high reset; release must be synchronous to DST_CLK
//   SRC_DATA_IN    asynchronous level input bus
//   DST_DATA_OUT   synchronized (optionally filtered) bus
//   DST_CHANGE_OUT high in each cycle where DST_DATA_OUT differs from the previous cycle
module async_level_sync #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               FILTER_CYCLES = 0
) (
  input  logic             DST_CLK,
  input  logic             DST_RESET_IN,
  input  logic [WIDTH-1:0] SRC_DATA_IN,
  output logic [WIDTH-1:0] DST_DATA_OUT,
  output logic             DST_CHANGE_OUT
);

  // Synchronizer chain, index 0 samples the asynchronous input. Declaration
  // values give the reset value at power-up for instances with reset tied low.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", KEEP = "TRUE" *)
  logic [STAGES-1:0][WIDTH-1:0] r_sync = {STAGES{RESET_VALUE}};

  logic [WIDTH-1:0] w_chain;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_prev = RESET_VALUE;

  always_ff @(posedge DST_CLK or posedge DST_RESET_IN) begin
    if (DST_RESET_IN) begin
      r_sync <= {STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], SRC_DATA_IN};
    end
  end

  assign w_chain = r_sync[STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign w_out = w_chain;
    end else begin : g_filter
      localparam logic [7:0] FILT = 8'(FILTER_CYCLES);

      logic [WIDTH-1:0] r_hold = RESET_VALUE;
      logic [7:0]       r_cnt  = '0;
      logic [WIDTH-1:0] r_out  = RESET_VALUE;

      // r_cnt counts consecutive cycles with the chain output unchanged; any
      // bit change restarts it, so the whole word is released in one cycle.
      always_ff @(posedge DST_CLK or posedge DST_RESET_IN) begin
        if (DST_RESET_IN) begin
          r_hold <= RESET_VALUE;
          r_cnt  <= '0;
          r_out  <= RESET_VALUE;
        end else begin
          r_hold <= w_chain;
          if (w_chain != r_hold) begin
            r_cnt <= '0;
          end else if (r_cnt < FILT) begin
            r_cnt <= r_cnt + 8'd1;
          end
          if ((r_cnt == FILT) && (r_hold != r_out)) begin
            r_out <= r_hold;
          end
        end
      end

      assign w_out = r_out;
    end
  endgenerate

  always_ff @(posedge DST_CLK or posedge DST_RESET_IN) begin
    if (DST_RESET_IN) begin
      r_prev <= RESET_VALUE;
    end else begin
      r_prev <= w_out;
    end
  end

  assign DST_DATA_OUT   = w_out;
  assign DST_CHANGE_OUT = (w_out != r_prev);

endmodule

// File: tb/tb_async_level_sync.sv
// tb_async_level_sync: four instances (bypass W1/S2, filtered W8/S3/F2 with two
//   reset values, bypass S4 with reset tied low) checked every cycle against a
//   sample-history reference model, plus directed latency/glitch/reset checks.
module tb_async_level_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v;
  logic [7:0] src [4];
  logic [7:0] obs [4];
  logic       o0, o3;
  logic [7:0] o1, o2;
  logic       c0, c1, c2, c3;
  logic [3:0] chg;

  async_level_sync #(.WIDTH(1), .STAGES(2), .RESET_VALUE(1'b0), .FILTER_CYCLES(0)) u0 (
    .DST_CLK(clk), .DST_RESET_IN(rst_v[0]), .SRC_DATA_IN(src[0][0]),
    .DST_DATA_OUT(o0), .DST_CHANGE_OUT(c0));
  async_level_sync #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00), .FILTER_CYCLES(2)) u1 (
    .DST_CLK(clk), .DST_RESET_IN(rst_v[1]), .SRC_DATA_IN(src[1]),
    .DST_DATA_OUT(o1), .DST_CHANGE_OUT(c1));
  async_level_sync #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hFF), .FILTER_CYCLES(2)) u2 (
    .DST_CLK(clk), .DST_RESET_IN(rst_v[2]), .SRC_DATA_IN(src[2]),
    .DST_DATA_OUT(o2), .DST_CHANGE_OUT(c2));
  async_level_sync #(.WIDTH(1), .STAGES(4), .RESET_VALUE(1'b0), .FILTER_CYCLES(0)) u3 (
    .DST_CLK(clk), .DST_RESET_IN(1'b0), .SRC_DATA_IN(src[3][0]),
    .DST_DATA_OUT(o3), .DST_CHANGE_OUT(c3));

  assign obs[0] = {7'd0, o0};
  assign obs[1] = o1;
  assign obs[2] = o2;
  assign obs[3] = {7'd0, o3};
  assign chg    = {c3, c2, c1, c0};

  // Per-instance configuration as seen by the model.
  int         s_p  [4] = '{2, 3, 3, 4};
  int         f_p  [4] = '{0, 2, 2, 0};
  logic [7:0] rv_p [4] = '{8'h00, 8'h00, 8'hFF, 8'h00};

  // Reference model state: input value seen at each rising edge since reset.
  logic [7:0] hist [4][4096];
  int         n_e [4]     = '{0, 0, 0, 0};
  logic [7:0] exp_cur [4] = '{8'h00, 8'h00, 8'hFF, 8'h00};
  logic [7:0] e_new [4];
  int         pulses [4]  = '{0, 0, 0, 0};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Synchronized value after edge k: the input seen STAGES-1 edges earlier.
  function automatic logic [7:0] chain_at(input int i, input int k);
    if (k - s_p[i] >= 0) return hist[i][k - s_p[i]];
    return rv_p[i];
  endfunction

  // Filtered output after edge n takes the synchronized value of edge n-2 once
  // the last FILTER+1 synchronized values (edges n-2-F..n-2) are identical.
  function automatic logic [7:0] model_out(input int i);
    int n;
    n = n_e[i];
    if (f_p[i] == 0) return chain_at(i, n);
    if (n - 1 < f_p[i]) return exp_cur[i];
    for (int k = n - 2 - f_p[i]; k < n - 2; k++) begin
      if (chain_at(i, k) != chain_at(i, n - 2)) return exp_cur[i];
    end
    return chain_at(i, n - 2);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_v[i] && n_e[i] < 4096) begin
        hist[i][n_e[i]] = src[i];
        n_e[i]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_v[i]) e_new[i] = rv_p[i];
      else          e_new[i] = model_out(i);
      check($sformatf("u%0d_data", i), obs[i], e_new[i]);
      check($sformatf("u%0d_chg", i), {7'd0, chg[i]}, {7'd0, (e_new[i] != exp_cur[i])});
      if (chg[i]) pulses[i]++;
      exp_cur[i] = e_new[i];
    end
  end

  // Inputs change 2 time units after a rising edge.
  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  // Returns at the falling edge following k more rising edges.
  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  int base;
  int n_tr;
  int hold;

  initial begin
    rst_v  = 4'b0111;
    src[0] = 8'h00;
    src[1] = 8'h00;
    src[2] = 8'h00;
    src[3] = 8'h01;

    // Reset tied low, input high from t=0: reset value until edge 4.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("u3_pwrup_e%0d", k), obs[3], (k == 4) ? 8'h01 : 8'h00);
    end
    check("u2_in_reset", obs[2], 8'hFF);
    check("u2_in_reset_chg", {7'd0, chg[2]}, 8'h00);

    // Bypass 2-stage: 0->1 and 1->0 both appear after edge 2.
    at_drive();
    rst_v  = 4'b0000;
    src[0] = 8'h01;
    wait_edges(1); check("u0_rise_e1", obs[0], 8'h00);
    wait_edges(1); check("u0_rise_e2", obs[0], 8'h01);
    check("u0_rise_pulse", {7'd0, chg[0]}, 8'h01);
    wait_edges(1); check("u0_rise_pulse_end", {7'd0, chg[0]}, 8'h00);
    at_drive();
    src[0] = 8'h00;
    wait_edges(1); check("u0_fall_e1", obs[0], 8'h01);
    wait_edges(1); check("u0_fall_e2", obs[0], 8'h00);
    wait_edges(4);

    // Filtered: 0x00 -> 0xA5 appears after edge 7 with one pulse.
    at_drive();
    base   = pulses[1];
    src[1] = 8'hA5;
    wait_edges(6); check("u1_a5_e6", obs[1], 8'h00);
    wait_edges(1); check("u1_a5_e7", obs[1], 8'hA5);
    check("u1_a5_pulse", {7'd0, chg[1]}, 8'h01);
    wait_edges(3); check("u1_a5_pulse_count", 8'(pulses[1] - base), 8'd1);
    at_drive();
    src[1] = 8'h00;
    wait_edges(12);

    // Filtered glitch: 0x3C held for two edges never reaches the output.
    at_drive();
    base   = pulses[1];
    src[1] = 8'h3C;
    at_drive();
    at_drive();
    src[1] = 8'h00;
    wait_edges(12);
    check("u1_glitch_data", obs[1], 8'h00);
    check("u1_glitch_pulses", 8'(pulses[1] - base), 8'd0);

    // Async reset mid-filter with input 0x12, reset value 0xFF.
    at_drive();
    src[2] = 8'h12;
    wait_edges(4);
    check("u2_prefilter", obs[2], 8'h00);
    #1;
    rst_v[2]   = 1'b1;
    n_e[2]     = 0;
    exp_cur[2] = 8'hFF;
    #1;
    check("u2_async_rst", obs[2], 8'hFF);
    check("u2_async_rst_chg", {7'd0, chg[2]}, 8'h00);
    at_drive();
    rst_v[2] = 1'b0;
    wait_edges(6); check("u2_rel_e6", obs[2], 8'hFF);
    wait_edges(1); check("u2_rel_e7", obs[2], 8'h12);
    check("u2_rel_pulse", {7'd0, chg[2]}, 8'h01);

    // Random toggling in bypass mode; every transition gives one pulse.
    base = pulses[0];
    n_tr = 0;
    for (int t = 0; t < 40; t++) begin
      at_drive();
      src[0] = {7'd0, ~src[0][0]};
      n_tr++;
      hold = $urandom_range(3, 20);
      repeat (hold - 1) @(posedge clk);
    end
    wait_edges(5);
    check("u0_rand_pulses", 8'(pulses[0] - base), 8'(n_tr));

    // Random words with random hold times through the filter.
    for (int t = 0; t < 30; t++) begin
      at_drive();
      src[1] = 8'($urandom);
      hold = $urandom_range(0, 11);
      repeat (hold) @(posedge clk);
    end
    wait_edges(12);
    check("u1_rand_final", obs[1], src[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
